// File: rtl/alu_retire_stage_pkg.sv
// Shared encodings for the ALU and its retire stage: op codes, execute
// conditions, retired-entry kinds, flag bit positions, condition helper.
package alu_retire_stage_pkg;

  // ALU operation that produced the result (shared with the ALU)
  typedef enum logic [1:0] {
    ADD_ARITH = 2'b00,
    NAND_OP   = 2'b01,
    EQUAL     = 2'b10,
    ADD_MEM   = 2'b11
  } alu_op_e;

  // Execute conditions
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_CARRY  = 2'b01;
  localparam logic [1:0] COND_ZERO   = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  // Retired entry kinds
  localparam logic [1:0] KIND_REG_WB   = 2'b00;
  localparam logic [1:0] KIND_MEM_ADDR = 2'b01;
  localparam logic [1:0] KIND_BRANCH   = 2'b10;

  // Flag bit positions
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  // Evaluate an execute condition against the architectural flags
  function automatic logic cond_pass(input logic [1:0] cond, input logic [1:0] flags);
    logic pass;
    pass = 1'b0;
    case (cond)
      COND_ALWAYS: pass = 1'b1;
      COND_CARRY:  pass = flags[FLAG_C];
      COND_ZERO:   pass = flags[FLAG_Z];
      default:     pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/alu_retire_stage_skid_buf.sv
// retire_skid_buf: 2-entry FIFO of packed retire entries with EMPTY/ONE/TWO FSM.
// Ports: clk, rst_n (sync, active-low), push/din (caller guarantees !full),
// pop (only meaningful while out_valid), out_valid/in_ready (registered),
// dout (head entry, registered).
module retire_skid_buf #(
  parameter int unsigned W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         out_valid,
  output logic         in_ready,
  output logic [W-1:0] dout
);

  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         out_valid_q;
  logic         in_ready_q;

  // Next state and next storage contents
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = din;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = din;                  // head leaves, new entry takes its place
        end else if (push) begin
          tail_d  = din;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;              // FIFO order: second entry moves up
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, storage and handshake flags, all registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign dout      = head_q;

endmodule

// File: rtl/alu_retire_stage.sv
// alu_retire_stage: captures ALU results, resolves conditional execution and
// equality branches, keeps the architectural flags and queues retired effects.
// Ports: clk, rst_n (sync, active-low); in_* ALU side with in_valid/in_ready;
// out_* consumer side with out_valid/out_ready; flags_q architectural flags;
// drop_cnt saturating count of accepted instructions that produced no entry.
module alu_retire_stage
  import alu_retire_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic [DATA_W-1:0] in_result,
  input  logic [1:0]        in_flags,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [1:0]        in_cond,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [REG_AW-1:0] out_dest,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        flags_q,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned ENTRY_W = 2 + REG_AW + DATA_W;

  logic              accept;
  logic              pass;
  logic              has_entry;
  logic              push;
  logic              pop;
  logic [1:0]        kind;
  logic [REG_AW-1:0] dest;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic [1:0]        flags_r;
  logic [CNT_W-1:0]  drop_r;

  // Decode the incoming instruction into an optional retire entry
  always_comb begin
    accept    = in_valid && in_ready;
    pass      = cond_pass(in_cond, flags_r);
    has_entry = 1'b0;
    kind      = KIND_REG_WB;
    dest      = '0;
    case (alu_op_e'(in_alu_op))
      ADD_ARITH, NAND_OP: begin
        has_entry = 1'b1;
        kind      = KIND_REG_WB;
        dest      = in_dest;
      end
      ADD_MEM: begin
        has_entry = 1'b1;
        kind      = KIND_MEM_ADDR;
      end
      EQUAL: begin
        has_entry = in_flags[FLAG_Z];    // branch taken only when operands equal
        kind      = KIND_BRANCH;
      end
      default: has_entry = 1'b0;
    endcase
    if (!pass) has_entry = 1'b0;
    push  = accept && has_entry;
    pop   = out_valid && out_ready;
    entry = {kind, dest, in_result};
  end

  // Architectural flags and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r <= 2'b00;
      drop_r  <= '0;
    end else if (accept) begin
      if (pass && in_flag_we) flags_r <= in_flags;
      if (!has_entry && (drop_r != {CNT_W{1'b1}})) drop_r <= drop_r + CNT_W'(1);
    end
  end

  retire_skid_buf #(.W(ENTRY_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .din       (entry),
    .pop       (pop),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .dout      (head)
  );

  assign out_kind = head[ENTRY_W-1 -: 2];
  assign out_dest = head[DATA_W +: REG_AW];
  assign out_data = head[DATA_W-1:0];
  assign flags_q  = flags_r;
  assign drop_cnt = drop_r;

endmodule

// File: tb/tb_alu_retire_stage.sv
// Self-checking bench for alu_retire_stage: vector table plus hand-written
// back-pressure, saturation and reset sequences, with a scoreboard queue.
module tb_alu_retire_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_op;
  logic [15:0] in_result;
  logic [1:0]  in_flags;
  logic [2:0]  in_dest;
  logic [1:0]  in_cond;
  logic        in_flag_we;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [2:0]  out_dest;
  logic [15:0] out_data;
  logic [1:0]  flags_q;
  logic [7:0]  drop_cnt;

  alu_retire_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_op  (in_alu_op),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_dest    (in_dest),
    .in_cond    (in_cond),
    .in_flag_we (in_flag_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_dest   (out_dest),
    .out_data   (out_data),
    .flags_q    (flags_q),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [15:0] res;
    logic [1:0]  flags;
    logic [2:0]  dest;
    logic [1:0]  cond;
    logic        we;
    logic        ordy;
    logic [1:0]  exp_flags;
    logic [7:0]  exp_drop;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  dest;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  m_flags;
  logic [7:0]  m_drop;
  int          n_total;
  int          n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model of the retire decision for one accepted instruction
  task automatic model_accept(input vec_t v);
    logic pass;
    exp_t e;
    pass = (v.cond == 2'b00) || (v.cond == 2'b01 && m_flags[1]) || (v.cond == 2'b10 && m_flags[0]);
    e.kind = 2'b00; e.dest = 3'd0; e.data = v.res;
    if (pass) begin
      if (v.op == 2'b00 || v.op == 2'b01) begin
        e.dest = v.dest;
        sb.push_back(e);
      end else if (v.op == 2'b11) begin
        e.kind = 2'b01;
        sb.push_back(e);
      end else if (v.flags[0]) begin
        e.kind = 2'b10;
        sb.push_back(e);
      end else if (m_drop != 8'hFF) begin
        m_drop = m_drop + 8'd1;
      end
      if (v.we) m_flags = v.flags;
    end else if (m_drop != 8'hFF) begin
      m_drop = m_drop + 8'd1;
    end
  endtask

  // One clock: drive at negedge, check handshake/head, advance, check state
  task automatic step(input vec_t v, output bit acc);
    bit pop;
    in_valid = v.valid; in_alu_op = v.op; in_result = v.res; in_flags = v.flags;
    in_dest = v.dest; in_cond = v.cond; in_flag_we = v.we; out_ready = v.ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(sb.size() != 2));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0 && out_valid) begin
      chk("out_kind", 32'(out_kind), 32'(sb[0].kind));
      chk("out_dest", 32'(out_dest), 32'(sb[0].dest));
      chk("out_data", 32'(out_data), 32'(sb[0].data));
    end
    pop = (sb.size() != 0) && v.ordy;
    acc = v.valid && (sb.size() != 2);
    if (pop) void'(sb.pop_front());
    if (acc) model_accept(v);
    @(posedge clk);
    @(negedge clk);
    chk("flags_q", 32'(flags_q), 32'(m_flags));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic reset_model();
    sb.delete();
    m_flags = 2'b00;
    m_drop  = 8'd0;
  endtask

  vec_t tbl[12];
  vec_t v;
  bit   acc;
  int   k;

  initial begin
    n_total = 0; n_pass = 0;
    reset_model();
    // 0:ADD always, 1:ADD sets carry, 2:if-carry taken, 3:if-zero dropped,
    // 4:EQUAL taken, 5:EQUAL not taken, 6:ADD_MEM, 7:NAND, 8:never,
    // 9:if-zero taken, 10:if-carry dropped, 11:idle
    tbl[0]  = '{1'b1, 2'b00, 16'h0006, 2'b00, 3'd3, 2'b00, 1'b1, 1'b1, 2'b00, 8'd0};
    tbl[1]  = '{1'b1, 2'b00, 16'h0011, 2'b10, 3'd1, 2'b00, 1'b1, 1'b1, 2'b10, 8'd0};
    tbl[2]  = '{1'b1, 2'b00, 16'h1234, 2'b00, 3'd5, 2'b01, 1'b0, 1'b1, 2'b10, 8'd0};
    tbl[3]  = '{1'b1, 2'b00, 16'h5555, 2'b01, 3'd4, 2'b10, 1'b1, 1'b1, 2'b10, 8'd1};
    tbl[4]  = '{1'b1, 2'b10, 16'h0000, 2'b01, 3'd0, 2'b00, 1'b1, 1'b1, 2'b01, 8'd1};
    tbl[5]  = '{1'b1, 2'b10, 16'h0002, 2'b00, 3'd2, 2'b00, 1'b1, 1'b1, 2'b00, 8'd2};
    tbl[6]  = '{1'b1, 2'b11, 16'h8000, 2'b00, 3'd6, 2'b00, 1'b0, 1'b1, 2'b00, 8'd2};
    tbl[7]  = '{1'b1, 2'b01, 16'hFFFE, 2'b11, 3'd7, 2'b00, 1'b1, 1'b1, 2'b11, 8'd2};
    tbl[8]  = '{1'b1, 2'b00, 16'h0000, 2'b00, 3'd0, 2'b11, 1'b1, 1'b1, 2'b11, 8'd3};
    tbl[9]  = '{1'b1, 2'b01, 16'hABCD, 2'b00, 3'd2, 2'b10, 1'b1, 1'b1, 2'b00, 8'd3};
    tbl[10] = '{1'b1, 2'b11, 16'h7777, 2'b11, 3'd1, 2'b01, 1'b1, 1'b1, 2'b00, 8'd4};
    tbl[11] = '{1'b0, 2'b00, 16'h0000, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1, 2'b00, 8'd4};

    // Reset held two cycles with a valid instruction presented
    rst_n = 1'b0;
    in_valid = 1'b1; in_alu_op = 2'b00; in_result = 16'h00AA; in_flags = 2'b11;
    in_dest = 3'd1; in_cond = 2'b00; in_flag_we = 1'b1; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      step(tbl[i], acc);
      chk("tbl_accept", 32'(acc), 32'(tbl[i].valid));
      chk("tbl_flags", 32'(flags_q), 32'(tbl[i].exp_flags));
      chk("tbl_drop", 32'(drop_cnt), 32'(tbl[i].exp_drop));
    end

    // Drop counter saturation
    v = '{1'b1, 2'b00, 16'h0001, 2'b00, 3'd1, 2'b11, 1'b1, 1'b1, 2'b00, 8'd0};
    for (int i = 0; i < 260; i++) step(v, acc);
    chk("drop_saturated", 32'(drop_cnt), 32'hFF);
    chk("flags_after_never", 32'(flags_q), 32'd0);

    // Back-pressure: three entries with consumer stalled for four cycles
    k = 1;
    for (int cyc = 0; cyc < 30 && (k <= 3 || sb.size() != 0); cyc++) begin
      v = '{(k <= 3), 2'b00, 16'(k), 2'b00, 3'(k), 2'b00, 1'b0, (cyc >= 4), 2'b00, 8'd0};
      step(v, acc);
      if (acc) k++;
      if (cyc == 3) chk("bp_held_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_all_accepted", 32'(k), 32'd4);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stream with the buffer full
    v = '{1'b1, 2'b00, 16'h0101, 2'b11, 3'd2, 2'b00, 1'b1, 1'b0, 2'b00, 8'd0};
    step(v, acc);
    v.res = 16'h0202; v.we = 1'b0;
    step(v, acc);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_flags", 32'(flags_q), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    v = '{1'b0, 2'b00, 16'h0000, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1, 2'b00, 8'd0};
    step(v, acc);
    step(v, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_retire_stage.md
Name: alu_retire_stage

Overview:
- Sits directly downstream of the 16-bit ALU.
- Each cycle it captures the ALU result and its {carry, zero} flags for a valid instruction, and holds the architectural flag register.
- Resolves conditional execution and equality branches, then queues the retired effect in a 2-entry skid buffer for the register-file/memory/fetch consumer.
- Decouples ALU timing from writeback back-pressure with a valid/ready handshake on both sides.

Parameters:
- DATA_W, 16, datapath width; must match the ALU.
- REG_AW, 3, destination register index width.
- CNT_W, 8, width of the saturating dropped-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  ALU output valid this cycle
- in_ready  out  1  stage can accept
- in_alu_op  in  2  op that produced the result: 00 ADD_ARITH, 01 NAND_OP, 10 EQUAL, 11 ADD_MEM
- in_result  in  DATA_W  ALU result
- in_flags  in  2  ALU flags, [1]=carry, [0]=zero
- in_dest  in  REG_AW  destination register
- in_cond  in  2  execute condition: 00 always, 01 if carry, 10 if zero, 11 never (nop)
- in_flag_we  in  1  instruction updates the flag register
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry
- out_kind  out  2  00 REG_WB, 01 MEM_ADDR, 10 BRANCH
- out_dest  out  REG_AW  destination register (REG_WB only, else 0)
- out_data  out  DATA_W  write data / memory address / branch operand
- flags_q  out  2  architectural flags, [1]=carry, [0]=zero
- drop_cnt  out  CNT_W  instructions retired without an output entry

Behaviour:
- Reset values (synchronous, rst_n low at posedge): buffer cleared, occupancy 0, out_valid=0, out_kind/out_dest/out_data=0, flags_q=00, drop_cnt=0. Asserting reset mid-operation discards buffered entries without popping them.
- Accept: accept = in_valid && in_ready, sampled at posedge. in_ready = (occupancy != 2), derived from registered state only; no combinational path from out_ready.
- Condition: pass = (cond==00) | (cond==01 & flags_q[1]) | (cond==10 & flags_q[0]). It uses flags_q from before the current instruction's update, which already includes any earlier accepted instruction.
- Flag update on accept: if pass && in_flag_we, flags_q <= in_flags at the same edge. If !pass, flags_q is unchanged.
- Entry generation on accept with pass:
  - op 00 or 01: REG_WB, dest=in_dest, data=in_result.
  - op 11: MEM_ADDR, dest=0, data=in_result.
  - op 10: BRANCH only if in_flags[0]==1 (operands equal), data=in_result; otherwise no entry.
- Drop counting: an accepted instruction that produces no entry (!pass, or EQUAL with operands not equal) increments drop_cnt, saturating at all-ones.
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. one cycle, when the buffer was empty.
- Buffer FSM, states EMPTY, ONE, TWO; push = accept with an entry; pop = out_valid && out_ready:
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to TWO. Pop without push goes to EMPTY. Push and pop together stay in ONE, with the new entry as head.
  - TWO: in_ready=0. Pop goes to ONE; the second entry becomes head in FIFO order.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Dropped instruction in a full buffer: in_ready is 0, so the instruction is never accepted and the flags are untouched.
- Arithmetic: no arithmetic beyond the counter; result and flags pass through unmodified.

Decomposition:
- Shared package holds:
  - ALU op codes (ADD_ARITH, NAND_OP, EQUAL, ADD_MEM), also used by the ALU.
  - COND_* encodings.
  - KIND_* encodings.
  - Flag bit indices FLAG_C=1, FLAG_Z=0.
- One sub-module: retire_skid_buf, a 2-entry FIFO carrying {kind, dest, data} with the EMPTY/ONE/TWO FSM. Condition, flag and counter logic stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, flags_q=00, drop_cnt=0, and nothing is accepted.
- ADD always: op=00, result=0x0006, flags=00, dest=3, flag_we=1, out_ready=1 -> next cycle out_valid=1, kind=REG_WB, dest=3, data=0x0006; flags_q=00.
- Conditional on carry: accept ADD with flags=10, flag_we=1 (flags_q becomes 10), then ADD cond=01 dest=5 data=0x1234 -> REG_WB dest=5 data=0x1234 is emitted. Next, cond=10 with flags_q=10 -> no entry, drop_cnt=1, flags_q unchanged.
- EQUAL: op=10, result=0x0000, flags=01 -> BRANCH, data=0x0000. Then op=10, result=0x0002, flags=00 -> no entry, drop_cnt increments.
- Back-pressure: out_ready=0, push three REG_WB entries (data 1, 2, 3) -> after two accepts in_ready=0 and the third is held. Raise out_ready -> outputs appear in order 1, 2, 3, with no loss and no duplication.
- Reset mid-stream: buffer in TWO, pulse rst_n low 1 cycle -> out_valid=0 the following cycle, buffered entries gone, flags_q=00.
